// File: rtl/time_entry_loader.sv
// ============================================================================
// time_entry_loader: keypad MM:SS entry, validated load strobe to the countdown
// counters, and run/done supervision.   Revision 1.0
// ============================================================================
`default_nettype none

module time_entry_loader (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_start,
  input  logic       key_clear,
  input  logic       zero_in,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic       en,
  output logic [2:0] digit_count,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    LD_SETUP = 3'd2,
    LD_PULSE = 3'd3,
    LD_HOLD  = 3'd4,
    RUN      = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t     state, state_nx;
  logic [3:0] mt_nx, mo_nx, st_nx, so_nx;
  logic [2:0] cnt_nx;
  logic       err_nx;
  logic       armed, armed_nx;
  logic       all_zero;

  assign all_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd0);

  always_comb begin
    state_nx = state;
    mt_nx    = min_tens;
    mo_nx    = min_ones;
    st_nx    = sec_tens;
    so_nx    = sec_ones;
    cnt_nx   = digit_count;
    err_nx   = 1'b0;
    armed_nx = 1'b0;
    if (key_clear) begin
      state_nx = IDLE;
      mt_nx    = 4'd0;
      mo_nx    = 4'd0;
      st_nx    = 4'd0;
      so_nx    = 4'd0;
      cnt_nx   = 3'd0;
    end else begin
      case (state)
        IDLE, ENTRY: begin
          // A start in ENTRY consumes the cycle even when it is rejected.
          if (key_start && (state == ENTRY)) begin
            if (all_zero) begin
              state_nx = ENTRY;
            end else if (sec_tens > 4'd5) begin
              err_nx = 1'b1;
            end else begin
              state_nx = LD_SETUP;
            end
          end else if (key_valid && (key_digit <= 4'd9) && (digit_count < 3'd4)) begin
            mt_nx    = min_ones;
            mo_nx    = sec_tens;
            st_nx    = sec_ones;
            so_nx    = key_digit;
            cnt_nx   = digit_count + 3'd1;
            state_nx = ENTRY;
          end
        end
        LD_SETUP: state_nx = LD_PULSE;
        LD_PULSE: state_nx = LD_HOLD;
        LD_HOLD:  state_nx = RUN;
        RUN: begin
          // armed is low during the first RUN cycle so a stale zero_in is ignored.
          armed_nx = 1'b1;
          if (armed && zero_in) state_nx = DONE;
        end
        DONE: begin
          state_nx = IDLE;
          mt_nx    = 4'd0;
          mo_nx    = 4'd0;
          st_nx    = 4'd0;
          so_nx    = 4'd0;
          cnt_nx   = 3'd0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      min_tens    <= 4'd0;
      min_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      digit_count <= 3'd0;
      armed       <= 1'b0;
      loadn       <= 1'b1;
      en          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nx;
      min_tens    <= mt_nx;
      min_ones    <= mo_nx;
      sec_tens    <= st_nx;
      sec_ones    <= so_nx;
      digit_count <= cnt_nx;
      armed       <= armed_nx;
      // Outputs are decoded from the next state so they align with the state register.
      loadn       <= (state_nx != LD_PULSE);
      en          <= (state_nx == RUN);
      busy        <= (state_nx != IDLE) && (state_nx != ENTRY);
      done        <= (state_nx == DONE);
      err         <= err_nx;
    end
  end

endmodule

`default_nettype wire
